hidden_cpu_exec: RTL and testbench
==================================

// Module: hidden_cpu_exec
// PURPOSE
//  Execute/write-back stage of the HiddenCPU. Consumes decoded instructions (opcode, rd, rs)
//  from the pin-level instruction latch, through a valid/ready handshake.
//  Holds the 4-entry register file r0..r3 and runs a 3-state FSM: IDLE -> EXEC -> WB.
//  Drives r3 onto the chip output pins, and exposes zero/carry flags.
// PARAMETERS
//  WIDTH    8   datapath and register width in bits; one register file of 4 x WIDTH
// PORTS
//  clk           in   1      single clock; all state updates on posedge clk
//  rst           in   1      synchronous, active-high reset
//  instr_valid   in   1      upstream presents an instruction this cycle
//  instr_ready   out  1      stage can accept; = (state==IDLE) && !rst
//  opcode        in   2      00 ADD, 01 SUB, 10 MOV, 11 XOR
//  rd_addr       in   2      destination (and first source) register index
//  rs_addr       in   2      second source register index
//  out           out  WIDTH  current value of r3, registered (chip output)
//  result_valid  out  1      1-cycle pulse in the cycle after a write-back commits
//  zero          out  1      result of last committed instruction == 0
//  carry         out  1      ADD carry-out / SUB borrow of last committed instruction
// BEHAVIOUR
//  Reset (rst=1 at posedge): r0=0, r1=1, r2=2, r3=3; state=IDLE; zero=0, carry=0;
//   result_valid=0; out=3. rst wins over every other event; an in-flight instr is dropped.
//  Handshake: accept at edge N iff instr_valid && instr_ready.
//   opcode/rd/rs are latched at N; later changes on the inputs are ignored.
//   instr_valid while !instr_ready has no side effect (no queueing).
//  FSM: IDLE --accept--> EXEC --> WB --> IDLE. No stalls, no other exits except rst.
//   EXEC (after edge N): read rd,rs values; compute result + flags into pipeline registers.
//   WB (after edge N+1): at edge N+2, write result to rd, update zero/carry, set
//    result_valid=1 for the following cycle, and return to IDLE.
//   instr_ready is high again after N+2; maximum throughput is 1 instr per 3 cycles.
//  Arithmetic: all results are modulo 2^WIDTH.
//   ADD: {carry,res} = rd + rs (WIDTH+1-bit sum).
//   SUB: res = rd - rs; carry = (rd < rs) unsigned borrow.
//   MOV: res = rs; carry = 0.
//   XOR: res = rd ^ rs; carry = 0.
//   zero = (res == 0) for all ops.
//  rd==rs: ADD doubles the value; SUB yields 0, zero=1, carry=0; MOV leaves reg unchanged
//   but still updates flags; XOR clears the reg, zero=1.
//  out tracks r3 and changes only at the WB edge that writes r3 (or at reset).
//   Writes to r0..r2 never change out.
//  Reset asserted in EXEC or WB: no register-file or flag update; reset values load.
//   Held rst keeps instr_ready=0.
//  Source operands are read in EXEC, after the previous WB has committed, so no hazard
//   logic is needed.
// TESTING
//  T1 reset: rst high 2 cycles -> out=3, zero=0, carry=0, instr_ready=1 on first cycle after rst low.
//  T2 ADD r3,r1 accepted at edge N -> instr_ready=0 during N..N+2; out=4, zero=0, carry=0 after edge N+2;
//     result_valid=1 for exactly one cycle.
//  T3 SUB r0,r1 (0-1) -> r0=0xFF, carry=1, zero=0; then SUB r1,r1 -> r1=0, zero=1, carry=0.
//  T4 overflow: MOV r3,r0 (r0=0xFF), then ADD r3,r2 (r2=2) -> out=0x01, carry=1, zero=0.
//  T5 backpressure: hold instr_valid with a changing opcode while busy -> only the first instr
//     (latched value) commits; later ones are accepted one per 3 cycles; no extra writes.
//  T6 reset mid-op: accept ADD r3,r3, assert rst in the WB cycle -> out=3 (not 6), flags 0,
//     no result_valid pulse.

Source files
------------

// File: rtl/hidden_cpu_exec.sv
`default_nettype none
// ============================================================================
//  Module   : hidden_cpu_exec
//  Purpose  : Execute/write-back stage of the HiddenCPU. Accepts one decoded
//             instruction through a valid/ready handshake, runs it through a
//             three-state sequence IDLE -> EXEC -> WB, and commits the result
//             into a 4-entry register file (r0..r3). r3 drives the chip pins.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             instr_valid/ready - instruction handshake (ready only in IDLE)
//             opcode            - 00 ADD, 01 SUB, 10 MOV, 11 XOR
//             rd_addr, rs_addr  - destination/first source, second source
//             out               - current value of r3
//             result_valid      - one-cycle pulse after a write-back commits
//             zero, carry       - flags of the last committed instruction
//  Revision : 1.0 - initial release
// ============================================================================
module hidden_cpu_exec #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [1:0]       opcode,
   input  logic [1:0]       rd_addr,
   input  logic [1:0]       rs_addr,
   output logic [WIDTH-1:0] out,
   output logic             result_valid,
   output logic             zero,
   output logic             carry
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_WB   = 2'd2;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MOV = 2'b10;
   localparam logic [1:0] OP_XOR = 2'b11;

   logic [1:0]       state;
   logic [1:0]       state_next;
   logic             accept;

   logic [1:0]       op_q;
   logic [1:0]       rd_q;
   logic [1:0]       rs_q;

   logic [WIDTH-1:0] regs [4];

   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] res_c;
   logic             carry_c;

   logic [WIDTH-1:0] res_q;
   logic             carry_q;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (accept) state_next = S_EXEC;
         S_EXEC:  state_next = S_WB;
         S_WB:    state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // Ready is gated by rst combinationally so a held reset never looks idle.
   always_comb begin
      instr_ready = (state == S_IDLE) && !rst;
   end

   assign accept = instr_valid && instr_ready;

   // Instruction latch: fields are frozen at the accept edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q <= OP_ADD;
         rd_q <= 2'd0;
         rs_q <= 2'd0;
      end else if (accept) begin
         op_q <= opcode;
         rd_q <= rd_addr;
         rs_q <= rs_addr;
      end
   end

   // Operands are read during EXEC; the previous write-back has already
   // committed by then, so no forwarding is required.
   assign src_a = regs[rd_q];
   assign src_b = regs[rs_q];
   assign sum   = {1'b0, src_a} + {1'b0, src_b};

   always_comb begin
      res_c   = '0;
      carry_c = 1'b0;
      case (op_q)
         OP_ADD: begin
            res_c   = sum[WIDTH-1:0];
            carry_c = sum[WIDTH];
         end
         OP_SUB: begin
            res_c   = src_a - src_b;
            carry_c = (src_a < src_b);
         end
         OP_MOV: res_c = src_b;
         OP_XOR: res_c = src_a ^ src_b;
         default: res_c = '0;
      endcase
   end

   // EXEC -> WB pipeline registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_q   <= '0;
         carry_q <= 1'b0;
      end else if (state == S_EXEC) begin
         res_q   <= res_c;
         carry_q <= carry_c;
      end
   end

   // Write-back: register file, flags and the completion pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            regs[i] <= WIDTH'(i);
         end
         zero         <= 1'b0;
         carry        <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         result_valid <= (state == S_WB);
         if (state == S_WB) begin
            regs[rd_q] <= res_q;
            zero       <= (res_q == '0);
            carry      <= carry_q;
         end
      end
   end

   assign out = regs[3];

endmodule
`default_nettype wire

// File: tb/tb_hidden_cpu_exec.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hidden_cpu_exec
//  Purpose  : Scoreboard bench for hidden_cpu_exec. A reference model tracks
//             architectural state (registers, flags, busy time) and pushes the
//             expected outcome of every accepted instruction; a monitor pops
//             and compares on each result_valid pulse and also checks ready,
//             out and flags every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hidden_cpu_exec;

   localparam int W    = 8;
   localparam int MASK = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         instr_valid = 1'b0;
   logic         instr_ready;
   logic [1:0]   opcode  = 2'd0;
   logic [1:0]   rd_addr = 2'd0;
   logic [1:0]   rs_addr = 2'd0;
   logic [W-1:0] out;
   logic         result_valid;
   logic         zero;
   logic         carry;

   hidden_cpu_exec #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .opcode       (opcode),
      .rd_addr      (rd_addr),
      .rs_addr      (rs_addr),
      .out          (out),
      .result_valid (result_valid),
      .zero         (zero),
      .carry        (carry)
   );

   always #5 clk = ~clk;

   typedef struct {
      int out_v;
      int zero_v;
      int carry_v;
      int cyc_v;
   } exp_t;

   exp_t exp_q[$];

   int checks  = 0;
   int errors  = 0;
   int cyc     = 0;
   int acc_cnt = 0;
   bit started = 0;

   // Committed architectural state of the model.
   int m_regs [4];
   int m_zero, m_carry;
   int busy;
   int p_rd, p_res, p_zero, p_carry;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            started = 1;
            for (int i = 0; i < 4; i++) m_regs[i] = i;
            m_zero  = 0;
            m_carry = 0;
            busy    = 0;
            exp_q.delete();
         end else if (!started) begin
            // nothing defined before the first reset
         end else if (busy > 0) begin
            busy--;
            if (busy == 0) begin
               m_regs[p_rd] = p_res;
               m_zero       = p_zero;
               m_carry      = p_carry;
            end
         end else if (instr_valid) begin
            int a, b, r, c;
            exp_t e;
            a = m_regs[rd_addr];
            b = m_regs[rs_addr];
            c = 0;
            case (opcode)
               2'b00: begin r = a + b; c = (r > MASK) ? 1 : 0; end
               2'b01: begin r = a - b; c = (a < b) ? 1 : 0; end
               2'b10: r = b;
               default: r = a ^ b;
            endcase
            r       = r & MASK;
            p_rd    = rd_addr;
            p_res   = r;
            p_zero  = (r == 0) ? 1 : 0;
            p_carry = c;
            busy    = 2;
            acc_cnt++;
            e.out_v   = (rd_addr == 2'd3) ? r : m_regs[3];
            e.zero_v  = p_zero;
            e.carry_v = c;
            e.cyc_v   = cyc + 2;
            exp_q.push_back(e);
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            check("instr_ready", int'(instr_ready), (busy == 0 && !rst) ? 1 : 0);
            check("out", int'(out), m_regs[3]);
            check("zero", int'(zero), m_zero);
            check("carry", int'(carry), m_carry);
            if (result_valid) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_result_valid", 1, 0);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  check("sb_out", int'(out), e.out_v);
                  check("sb_zero", int'(zero), e.zero_v);
                  check("sb_carry", int'(carry), e.carry_v);
                  check("sb_latency", cyc, e.cyc_v);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs);
      int start;
      bit done;
      start = acc_cnt;
      done  = 0;
      opcode = op; rd_addr = rd; rs_addr = rs; instr_valid = 1'b1;
      for (int k = 0; k < 20 && !done; k++) begin
         @(posedge clk); #1;
         if (acc_cnt != start) done = 1;
      end
      instr_valid = 1'b0;
      if (!done) check("accept_timeout", 0, 1);
   endtask

   // Returns at the negedge of the cycle following the commit edge.
   task automatic wait_commit();
      repeat (2) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      // T1: reset for two cycles
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("t1_ready", int'(instr_ready), 1);
      check("t1_out", int'(out), 3);
      @(posedge clk); #1;

      // T2: ADD r3,r1 -> 4
      issue(2'b00, 2'd3, 2'd1);
      wait_commit();
      check("t2_out", int'(out), 4);
      check("t2_rv", int'(result_valid), 1);
      @(negedge clk);
      check("t2_rv_once", int'(result_valid), 0);
      @(posedge clk); #1;

      // T3: SUB r0,r1 -> FF borrow; SUB r1,r1 -> 0
      issue(2'b01, 2'd0, 2'd1);
      wait_commit();
      check("t3_carry", int'(carry), 1);
      check("t3_zero", int'(zero), 0);
      @(posedge clk); #1;
      issue(2'b01, 2'd1, 2'd1);
      wait_commit();
      check("t3b_zero", int'(zero), 1);
      check("t3b_carry", int'(carry), 0);
      @(posedge clk); #1;

      // T4: MOV r3,r0 then ADD r3,r2 -> 0x01 with carry
      issue(2'b10, 2'd3, 2'd0);
      wait_commit();
      check("t4_mov", int'(out), 8'hFF);
      @(posedge clk); #1;
      issue(2'b00, 2'd3, 2'd2);
      wait_commit();
      check("t4_out", int'(out), 1);
      check("t4_carry", int'(carry), 1);
      @(posedge clk); #1;

      // T5: valid held high with opcode changing every cycle
      rd_addr = 2'd3; rs_addr = 2'd1; instr_valid = 1'b1;
      for (int k = 0; k < 12; k++) begin
         opcode = 2'($urandom_range(0, 3));
         @(posedge clk); #1;
      end
      instr_valid = 1'b0;
      repeat (4) @(posedge clk); #1;

      // T6: ADD r3,r3 with reset asserted during WB
      issue(2'b00, 2'd3, 2'd3);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("t6_out", int'(out), 3);
      check("t6_rv", int'(result_valid), 0);
      @(posedge clk); #1;

      // Randomized traffic with occasional resets
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
         end
         issue(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end

      repeat (5) @(posedge clk);
      @(negedge clk);
      check("sb_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
